// File: rtl/mosi_pkg.sv
// Shared MOSI/MISO channel types for the memory-controller front end.
package mosi_pkg;

  localparam int unsigned MOSI_DATA_W = 8;
  localparam int unsigned MAX_REQ     = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
  typedef logic [MOSI_DATA_W-1:0]     mosi_beat_t;

endpackage

// File: rtl/mosi_tag_fifo.sv
// In-order FIFO of requester ids; one entry per MOSI beat that expects a MISO response.
module mosi_tag_fifo
  import mosi_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  req_id_t         push_id,
  input  logic            pop,
  output req_id_t         head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  req_id_t         mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  always_comb begin
    full    = (count_q == CntW'(Depth));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_id;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/mosi_rr_arbiter.sv
// Round-robin MOSI arbiter with a one-beat output register; MISO responses are steered
// back to their originators through an in-order tag FIFO.
module mosi_rr_arbiter
  import mosi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = MOSI_DATA_W,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned CntW     = $clog2(MAX_OUTST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_mosi_data_i,
  input  logic [NUM_REQ-1:0]        req_mosi_valid_i,
  input  logic [NUM_REQ-1:0]        req_mosi_rsp_i,
  output logic [NUM_REQ-1:0]        req_mosi_ready_o,
  output logic [DATA_W-1:0]         req_miso_data_o,
  output logic [NUM_REQ-1:0]        req_miso_valid_o,
  input  logic [NUM_REQ-1:0]        req_miso_ready_i,
  output logic [DATA_W-1:0]         mosi_data_o,
  output logic                      mosi_valid_o,
  input  logic                      mosi_ready_i,
  input  logic [DATA_W-1:0]         miso_data_i,
  input  logic                      miso_valid_i,
  output logic                      miso_ready_o,
  output logic [CntW-1:0]           outstanding_o,
  output logic                      err_unexp_rsp_o
);

  req_id_t             rr_q, grant_id, fifo_head;
  logic                grant_valid, grant_rsp, load;
  logic [NUM_REQ-1:0]  elig, grant_oh, head_oh;
  logic [DATA_W-1:0]   grant_data, mosi_data_q;
  logic                mosi_valid_q, err_q;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;

  // Full is the registered occupancy, so a pop never frees a slot for a same-cycle push.
  always_comb begin
    elig = req_mosi_valid_i & ~(req_mosi_rsp_i & {NUM_REQ{fifo_full}});
  end

  // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && elig[k] && (k >= 32'(rr_q))) begin
        grant_valid = 1'b1;
        grant_id    = req_id_t'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && elig[k]) begin
        grant_valid = 1'b1;
        grant_id    = req_id_t'(k);
      end
    end
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    grant_rsp  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant_oh[k] = grant_valid && (grant_id == req_id_t'(k));
      grant_data  = grant_data | (req_mosi_data_i[k*DATA_W +: DATA_W] & {DATA_W{grant_oh[k]}});
      grant_rsp   = grant_rsp | (grant_oh[k] & req_mosi_rsp_i[k]);
    end
    load             = grant_valid & (~mosi_valid_q | mosi_ready_i) & ~rst;
    req_mosi_ready_o = grant_oh & {NUM_REQ{load}};
    fifo_push        = load & grant_rsp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_valid_q <= 1'b0;
      mosi_data_q  <= '0;
      rr_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      if (load) begin
        mosi_valid_q <= 1'b1;
        mosi_data_q  <= grant_data;
        rr_q         <= (32'(grant_id) + 1 >= NUM_REQ) ? '0 : grant_id + 1'b1;
      end else if (mosi_ready_i) begin
        mosi_valid_q <= 1'b0;
      end
      if (miso_valid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Responses with no outstanding tag are accepted and dropped so the controller never stalls.
  always_comb begin
    head_oh      = '0;
    miso_ready_o = fifo_empty;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      head_oh[k]   = ~fifo_empty && (fifo_head == req_id_t'(k));
      miso_ready_o = miso_ready_o | (head_oh[k] & req_miso_ready_i[k]);
    end
    req_miso_valid_o = head_oh & {NUM_REQ{miso_valid_i & ~rst}};
    fifo_pop         = miso_valid_i & miso_ready_o & ~fifo_empty;
    req_miso_data_o  = miso_data_i;
    mosi_data_o      = mosi_data_q;
    mosi_valid_o     = mosi_valid_q;
    outstanding_o    = fifo_count;
    err_unexp_rsp_o  = err_q;
  end

  mosi_tag_fifo #(
    .Depth (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (grant_id),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mosi_rr_arbiter.sv
// Directed bench for mosi_rr_arbiter; MOSI and MISO monitors check against scoreboard queues.
module tb_mosi_rr_arbiter;
  import mosi_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = MOSI_DATA_W;
  localparam int unsigned D = 8;
  localparam int unsigned CW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  req_mosi_data_i;
  logic [N-1:0]    req_mosi_valid_i, req_mosi_rsp_i, req_mosi_ready_o;
  logic [W-1:0]    req_miso_data_o;
  logic [N-1:0]    req_miso_valid_o, req_miso_ready_i;
  logic [W-1:0]    mosi_data_o, miso_data_i;
  logic            mosi_valid_o, mosi_ready_i, miso_valid_i, miso_ready_o;
  logic [CW-1:0]   outstanding_o;
  logic            err_unexp_rsp_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]   mosi_exp[$];
  logic [N+W-1:0] miso_exp[$];

  always #5 clk = ~clk;

  mosi_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .MAX_OUTST (D)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_mosi_data_i  (req_mosi_data_i),
    .req_mosi_valid_i (req_mosi_valid_i),
    .req_mosi_rsp_i   (req_mosi_rsp_i),
    .req_mosi_ready_o (req_mosi_ready_o),
    .req_miso_data_o  (req_miso_data_o),
    .req_miso_valid_o (req_miso_valid_o),
    .req_miso_ready_i (req_miso_ready_i),
    .mosi_data_o      (mosi_data_o),
    .mosi_valid_o     (mosi_valid_o),
    .mosi_ready_i     (mosi_ready_i),
    .miso_data_i      (miso_data_i),
    .miso_valid_i     (miso_valid_i),
    .miso_ready_o     (miso_ready_o),
    .outstanding_o    (outstanding_o),
    .err_unexp_rsp_o  (err_unexp_rsp_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe();
    #2;
  endtask

  task automatic set_slice(input int k, input logic [W-1:0] v);
    req_mosi_data_i[k*W +: W] = v;
  endtask

  // MOSI monitor: every accepted downstream beat must match the next expected beat.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && mosi_valid_o === 1'b1 && mosi_ready_i === 1'b1) begin
        if (mosi_exp.size() == 0) check("mosi_unexpected_beat", 32'(mosi_data_o), 32'hffff_ffff);
        else check("mosi_beat", 32'(mosi_data_o), 32'(mosi_exp.pop_front()));
      end
    end
  end

  // MISO monitor: every routed response handshake must match owner and data.
  initial begin
    forever begin
      @(negedge clk);
      if (miso_valid_i === 1'b1 && miso_ready_o === 1'b1 && req_miso_valid_o != '0) begin
        if (miso_exp.size() == 0) begin
          check("miso_unexpected_rsp", 32'({req_miso_valid_o, req_miso_data_o}), 32'hffff_ffff);
        end else begin
          check("miso_route", 32'({req_miso_valid_o, req_miso_data_o}), 32'(miso_exp.pop_front()));
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    req_mosi_valid_i = '1;
    req_mosi_rsp_i   = '0;
    req_miso_ready_i = '1;
    mosi_ready_i     = 1'b1;
    miso_valid_i     = 1'b0;
    miso_data_i      = '0;
    for (int k = 0; k < N; k++) set_slice(k, W'(8'h10 + k));

    // Reset with every requester valid.
    cyc(1);
    probe();
    check("rst_ready", 32'(req_mosi_ready_o), 32'h0);
    check("rst_mosi_valid", 32'(mosi_valid_o), 32'h0);
    check("rst_outstanding", 32'(outstanding_o), 32'h0);
    check("rst_err", 32'(err_unexp_rsp_o), 32'h0);
    cyc(1);
    rst = 1'b0;
    probe();
    check("first_grant", 32'(req_mosi_ready_o), 32'h1);
    mosi_exp.push_back(8'h10); mosi_exp.push_back(8'h11); mosi_exp.push_back(8'h12);
    mosi_exp.push_back(8'h13); mosi_exp.push_back(8'h10);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      probe();
      check("rr_grant", 32'(req_mosi_ready_o), 32'(1 << ((i + 1) % 4)));
    end
    cyc(1);
    req_mosi_valid_i = '0;
    cyc(2);

    // Requesters 1 and 3 alternate; no responses expected.
    set_slice(1, 8'h21);
    set_slice(3, 8'h23);
    req_mosi_valid_i = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      mosi_exp.push_back(8'h21);
      mosi_exp.push_back(8'h23);
    end
    cyc(6);
    req_mosi_valid_i = '0;
    probe();
    check("alt_outstanding", 32'(outstanding_o), 32'h0);
    cyc(2);

    // Downstream stall holds the beat; release loads the next beat in the same cycle.
    mosi_ready_i     = 1'b0;
    set_slice(0, 8'hA5);
    req_mosi_valid_i = 4'b0001;
    mosi_exp.push_back(8'hA5);
    cyc(1);
    set_slice(0, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      probe();
      check("stall_data", 32'(mosi_data_o), 32'hA5);
      check("stall_ready", 32'(req_mosi_ready_o), 32'h0);
      cyc(1);
    end
    mosi_ready_i = 1'b1;
    probe();
    check("release_load", 32'(req_mosi_ready_o), 32'h1);
    mosi_exp.push_back(8'h5A);
    cyc(1);
    req_mosi_valid_i = '0;
    cyc(2);

    // Fill the tag FIFO from requester 2; it is then blocked while requester 0 is not.
    set_slice(2, 8'h32);
    req_mosi_rsp_i   = 4'b0100;
    req_mosi_valid_i = 4'b0100;
    for (int i = 0; i < 8; i++) mosi_exp.push_back(8'h32);
    cyc(10);
    probe();
    check("full_outstanding", 32'(outstanding_o), 32'd8);
    check("full_blocked", 32'(req_mosi_ready_o), 32'h0);
    set_slice(0, 8'h40);
    req_mosi_valid_i = 4'b0101;
    #1;
    check("full_other_granted", 32'(req_mosi_ready_o), 32'h1);
    mosi_exp.push_back(8'h40);
    cyc(1);
    req_mosi_valid_i = 4'b0100;
    miso_valid_i     = 1'b1;
    miso_data_i      = 8'h77;
    miso_exp.push_back({4'b0100, 8'h77});
    probe();
    check("full_rsp_valid", 32'(req_miso_valid_o), 32'h4);
    check("full_rsp_ready", 32'(miso_ready_o), 32'h1);
    check("full_no_push_on_pop", 32'(req_mosi_ready_o), 32'h0);
    cyc(1);
    miso_valid_i = 1'b0;
    probe();
    check("regrant_after_pop", 32'(req_mosi_ready_o), 32'h4);
    mosi_exp.push_back(8'h32);
    cyc(1);
    req_mosi_valid_i = '0;
    req_mosi_rsp_i   = '0;
    probe();
    check("refill_outstanding", 32'(outstanding_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      miso_valid_i = 1'b1;
      miso_data_i  = W'(8'h80 + i);
      miso_exp.push_back({4'b0100, W'(8'h80 + i)});
      cyc(1);
    end
    miso_valid_i = 1'b0;
    probe();
    check("drain_outstanding", 32'(outstanding_o), 32'h0);
    cyc(1);

    // In-order response steering for requesters 0, 3, 1.
    set_slice(0, 8'h50); set_slice(3, 8'h53); set_slice(1, 8'h51);
    req_mosi_valid_i = 4'b0001; req_mosi_rsp_i = 4'b0001; mosi_exp.push_back(8'h50);
    cyc(1);
    req_mosi_valid_i = 4'b1000; req_mosi_rsp_i = 4'b1000; mosi_exp.push_back(8'h53);
    cyc(1);
    req_mosi_valid_i = 4'b0010; req_mosi_rsp_i = 4'b0010; mosi_exp.push_back(8'h51);
    cyc(1);
    req_mosi_valid_i = '0;
    req_mosi_rsp_i   = '0;
    cyc(2);
    probe();
    check("order_outstanding", 32'(outstanding_o), 32'd3);
    cyc(1);
    miso_valid_i = 1'b1;
    miso_data_i  = 8'h11;
    miso_exp.push_back({4'b0001, 8'h11});
    probe();
    check("order_rsp0", 32'(req_miso_valid_o), 32'h1);
    cyc(1);
    miso_data_i      = 8'h22;
    req_miso_ready_i = 4'b0111;
    miso_exp.push_back({4'b1000, 8'h22});
    for (int i = 0; i < 3; i++) begin
      probe();
      check("stall_miso_ready", 32'(miso_ready_o), 32'h0);
      check("stall_miso_valid", 32'(req_miso_valid_o), 32'h8);
      cyc(1);
    end
    req_miso_ready_i = '1;
    probe();
    check("release_miso_ready", 32'(miso_ready_o), 32'h1);
    cyc(1);
    miso_data_i = 8'h33;
    miso_exp.push_back({4'b0010, 8'h33});
    probe();
    check("order_rsp1", 32'(req_miso_valid_o), 32'h2);
    cyc(1);
    miso_valid_i = 1'b0;
    probe();
    check("order_drained", 32'(outstanding_o), 32'h0);
    cyc(1);

    // Unexpected response with an empty FIFO: dropped, sticky error until reset.
    miso_valid_i = 1'b1;
    miso_data_i  = 8'h99;
    probe();
    check("unexp_ready", 32'(miso_ready_o), 32'h1);
    check("unexp_no_valid", 32'(req_miso_valid_o), 32'h0);
    check("unexp_err_same_cycle", 32'(err_unexp_rsp_o), 32'h0);
    cyc(1);
    miso_valid_i = 1'b0;
    probe();
    check("unexp_err_set", 32'(err_unexp_rsp_o), 32'h1);
    cyc(3);
    probe();
    check("unexp_err_sticky", 32'(err_unexp_rsp_o), 32'h1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    probe();
    check("unexp_err_cleared", 32'(err_unexp_rsp_o), 32'h0);
    cyc(2);

    check("mosi_queue_empty", 32'(mosi_exp.size()), 32'h0);
    check("miso_queue_empty", 32'(miso_exp.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
